// File: rtl/audio_pkg.sv
// Shared audio types and default constants for the effects chain.
// Contents:
//   sample_t              signed 16-bit channel sample
//   stereo_t              packed {left, right} pair
//   DEFAULT_SAMPLE_WIDTH  bits per channel sample
//   DEFAULT_SLOT_WIDTH    BCLK periods per I2S channel slot
//   DEFAULT_BCLK_DIV      system clocks per BCLK half-period
package audio_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH = 16;
  localparam int DEFAULT_SLOT_WIDTH   = 32;
  localparam int DEFAULT_BCLK_DIV     = 4;

  typedef logic signed [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample handshake between the effects chain and the I2S transmitter.
//
// Handshake: a pair transfers on every rising clk edge where sampleValid and
// sampleReady are both high. While sampleValid is high and sampleReady is low,
// the source holds leftSampleIn/rightSampleIn stable. sampleReady does not
// depend on sampleValid in the same cycle.
//
// Signals:
//   leftSampleIn   signed left sample   (master -> slave)
//   rightSampleIn  signed right sample  (master -> slave)
//   sampleValid    pair valid           (master -> slave)
//   sampleReady    holding reg empty    (slave -> master)
interface i2s_transmitter_if
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH
);

  logic signed [SAMPLE_WIDTH-1:0] leftSampleIn;
  logic signed [SAMPLE_WIDTH-1:0] rightSampleIn;
  logic                           sampleValid;
  logic                           sampleReady;

  modport master (
    output leftSampleIn,
    output rightSampleIn,
    output sampleValid,
    input  sampleReady
  );

  modport slave (
    input  leftSampleIn,
    input  rightSampleIn,
    input  sampleValid,
    output sampleReady
  );

endinterface

// File: rtl/i2s_clock_gen.sv
// BCLK divider and frame bit counter for the I2S transmitter.
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   bclk_o          bit clock (registered)
//   lrclk_o         word select, 0 = left, 1 = right (registered)
//   fall_event_o    high in the clk cycle whose edge drives bclk 1 -> 0
//   slot_bit_o      position inside the slot that the coming fall enters
//   right_slot_o    the coming fall enters the right slot
//   frame_wrap_o    the coming fall wraps the bit counter to 0
// The slot outputs describe the counter value *after* the fall event so the
// top level can register sdata on the same edge that advances the counter.
module i2s_clock_gen #(
  parameter int SLOT_WIDTH = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          bclk_o,
  output logic                          lrclk_o,
  output logic                          fall_event_o,
  output logic [$clog2(SLOT_WIDTH)-1:0] slot_bit_o,
  output logic                          right_slot_o,
  output logic                          frame_wrap_o
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_WIDTH);
  localparam int KW = $clog2(SLOT_WIDTH);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] SLOT     = BW'(SLOT_WIDTH);

  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          lrclk_q, lrclk_d;

  logic          div_end;
  logic          fall;
  logic [BW-1:0] bit_next;
  logic          right_next;

  always_comb begin
    div_end    = (div_q == DIV_LAST);
    div_d      = div_end ? '0 : div_q + DW'(1);
    bclk_d     = div_end ? ~bclk_q : bclk_q;
    fall       = div_end & bclk_q;

    bit_next   = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
    right_next = (bit_next >= SLOT);

    bit_d      = fall ? bit_next : bit_q;
    lrclk_d    = fall ? right_next : lrclk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      bit_q   <= BIT_LAST;
      lrclk_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      bit_q   <= bit_d;
      lrclk_q <= lrclk_d;
    end
  end

  assign bclk_o       = bclk_q;
  assign lrclk_o      = lrclk_q;
  assign fall_event_o = fall;
  assign right_slot_o = right_next;
  assign frame_wrap_o = (bit_next == '0);
  assign slot_bit_o   = right_next ? KW'(bit_next - SLOT) : KW'(bit_next);

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter with a one-frame holding buffer.
// Ports:
//   clk, rst_n   system clock, async active-low reset
//   smp          sample handshake (slave side): leftSampleIn, rightSampleIn,
//                sampleValid in; sampleReady out (= holding register empty)
//   bclk         I2S bit clock
//   lrclk        I2S word select, 0 = left, 1 = right
//   sdata        I2S serial data, MSB first, one BCLK after the lrclk change
//   frameStart   one-clk pulse when a frame is loaded into the shifter
//   underrun     one-clk pulse when a frame load finds the holding reg empty
// Samples are sent bit-exact, MSB-justified in each slot; remaining slot
// bits are zero. On an underrun the previous pair is sent again.
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = DEFAULT_SLOT_WIDTH,
  parameter int BCLK_DIV     = DEFAULT_BCLK_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  i2s_transmitter_if.slave  smp,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              frameStart,
  output logic              underrun
);

  localparam int KW = $clog2(SLOT_WIDTH);
  localparam logic [KW-1:0] SW_K = KW'(SAMPLE_WIDTH);

  logic          fall_event;
  logic [KW-1:0] slot_bit;
  logic          right_slot;
  logic          frame_wrap;

  i2s_clock_gen #(
    .SLOT_WIDTH (SLOT_WIDTH),
    .BCLK_DIV   (BCLK_DIV)
  ) u_clock_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .bclk_o       (bclk),
    .lrclk_o      (lrclk),
    .fall_event_o (fall_event),
    .slot_bit_o   (slot_bit),
    .right_slot_o (right_slot),
    .frame_wrap_o (frame_wrap)
  );

  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [SAMPLE_WIDTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic                    sdata_q, sdata_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;

  logic                    accept;
  logic                    load;
  logic [SAMPLE_WIDTH-1:0] word;
  logic [SAMPLE_WIDTH-1:0] shifted;

  always_comb begin
    accept        = smp.sampleValid & ~hold_full_q;
    load          = fall_event & frame_wrap;

    hold_full_d   = hold_full_q;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    act_l_d       = act_l_q;
    act_r_d       = act_r_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    if (load) begin
      frame_start_d = 1'b1;
      if (hold_full_q) begin
        act_l_d     = hold_l_q;
        act_r_d     = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        underrun_d  = 1'b1;
      end
    end

    // Accept only happens while holding is empty, so it never races a
    // full-holding load; with an empty-holding load it fills for next frame.
    if (accept) begin
      hold_l_d    = smp.leftSampleIn;
      hold_r_d    = smp.rightSampleIn;
      hold_full_d = 1'b1;
    end

    // Slot position k (1..SAMPLE_WIDTH) sends bit SAMPLE_WIDTH-k: shifting
    // left by k-1 brings that bit to the MSB.
    word    = right_slot ? act_r_q : act_l_q;
    shifted = word << (slot_bit - KW'(1));
    if (fall_event) begin
      sdata_d = (slot_bit != '0) && (slot_bit <= SW_K) ? shifted[SAMPLE_WIDTH-1] : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      act_l_q       <= '0;
      act_r_q       <= '0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_full_q   <= hold_full_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      act_l_q       <= act_l_d;
      act_r_q       <= act_r_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign smp.sampleReady = ~hold_full_q;
  assign sdata           = sdata_q;
  assign frameStart      = frame_start_q;
  assign underrun        = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter with default parameters (16-bit samples,
// 32-bit slots, BCLK_DIV = 4). A driver issues directed pairs and pushes the
// expected frame {underrun, left, right} into exp_q; a monitor pops one entry
// per frameStart, deserialises 64 bits on bclk rising edges and compares.
module tb_i2s_transmitter;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_transmitter_if #(.SAMPLE_WIDTH(16)) smp ();
  logic bclk, lrclk, sdata, frameStart, underrun;

  i2s_transmitter #(
    .SAMPLE_WIDTH (16),
    .SLOT_WIDTH   (32),
    .BCLK_DIV     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .smp        (smp),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .sdata      (sdata),
    .frameStart (frameStart),
    .underrun   (underrun)
  );

  int tests_run = 0;
  int fails = 0;
  int frames_done = 0;
  int n;
  logic [32:0] exp_q[$];

  // clk rising edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (n=%0d)", name, got, exp, n);
    end
  endtask

  task automatic wait_until(input int t);
    while (n < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bclk"},  64'(bclk), 64'(0));
    check({tag, "_lrclk"}, 64'(lrclk), 64'(0));
    check({tag, "_sdata"}, 64'(sdata), 64'(0));
    check({tag, "_ready"}, 64'(smp.sampleReady), 64'(1));
    check({tag, "_fs"},    64'(frameStart), 64'(0));
    check({tag, "_und"},   64'(underrun), 64'(0));
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r, output int acc_n);
    int budget;
    budget = 0;
    smp.leftSampleIn  = l;
    smp.rightSampleIn = r;
    smp.sampleValid   = 1'b1;
    while (!smp.sampleReady && budget < 1200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("ready_timeout", 64'(budget >= 1200), 64'(0));
    if (budget < 1200) begin
      @(posedge clk);
      #1;
    end
    smp.sampleValid = 1'b0;
    acc_n = n;
  endtask

  // Monitor
  logic [63:0] bits;
  logic [32:0] cur;
  logic [15:0] got_l, got_r;
  logic [63:0] pad;
  logic        prev_bclk;
  logic        collecting;
  int          idx;
  int          lr_err;

  initial begin
    collecting = 1'b0;
    prev_bclk  = 1'b0;
    idx        = 0;
    lr_err     = 0;
    bits       = '0;
    cur        = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        collecting = 1'b0;
        prev_bclk  = 1'b0;
      end else begin
        if (frameStart) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            fails++;
            $display("FAIL unexpected_frame: frameStart with empty queue (n=%0d)", n);
            collecting = 1'b0;
          end else begin
            cur = exp_q.pop_front();
            check("underrun_flag", 64'(underrun), 64'(cur[32]));
            collecting = 1'b1;
            idx        = 0;
            lr_err     = 0;
            bits       = '0;
          end
        end else if (underrun) begin
          tests_run++;
          fails++;
          $display("FAIL stray_underrun: underrun without frameStart (n=%0d)", n);
        end
        if (collecting && bclk && !prev_bclk) begin
          bits[idx] = sdata;
          if (lrclk !== (idx >= 32)) lr_err++;
          idx++;
          if (idx == 64) begin
            collecting = 1'b0;
            frames_done++;
            pad = bits;
            for (int k = 1; k <= 16; k++) begin
              got_l[16-k] = bits[k];
              got_r[16-k] = bits[32+k];
              pad[k]      = 1'b0;
              pad[32+k]   = 1'b0;
            end
            check("left_word",  64'(got_l), 64'(cur[31:16]));
            check("right_word", 64'(got_r), 64'(cur[15:0]));
            check("pad_bits",   pad, 64'(0));
            check("lrclk_slot", 64'(lr_err), 64'(0));
          end
        end
        prev_bclk = bclk;
      end
    end
  end

  // Driver
  initial begin
    int acc;
    smp.leftSampleIn  = '0;
    smp.rightSampleIn = '0;
    smp.sampleValid   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset0");

    // Idle stream: underrun frames of zero
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(3);   check("bclk_low_n3",  64'(bclk), 64'(0));
    wait_until(4);   check("bclk_rise_n4", 64'(bclk), 64'(1));
    wait_until(7);   check("fs_n7",        64'(frameStart), 64'(0));
    wait_until(8);   check("fs_n8",        64'(frameStart), 64'(1));
                     check("und_n8",       64'(underrun), 64'(1));
    wait_until(263); check("lrclk_n263",   64'(lrclk), 64'(0));
    wait_until(264); check("lrclk_n264",   64'(lrclk), 64'(1));
    wait_until(520); check("und_n520",     64'(underrun), 64'(1));
    wait_until(1030);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset1");
    exp_q.delete();

    // Data frames A, B, C, then a repeated C on underrun
    exp_q.push_back({1'b0, 16'h8001, 16'h7FFE});
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h8001, 16'h7FFE, acc);
    check("acc_a_n",    64'(acc), 64'(1));
    check("ready_a",    64'(smp.sampleReady), 64'(0));
    wait_until(7);  check("ready_n7", 64'(smp.sampleReady), 64'(0));
    wait_until(8);  check("fs_a",     64'(frameStart), 64'(1));
                    check("und_a",    64'(underrun), 64'(0));
                    check("ready_n8", 64'(smp.sampleReady), 64'(1));
    wait_until(10);
    exp_q.push_back({1'b0, 16'h5A3C, 16'hC3A5});
    send(16'h5A3C, 16'hC3A5, acc);
    check("acc_b_n", 64'(acc), 64'(11));
    check("ready_b", 64'(smp.sampleReady), 64'(0));
    exp_q.push_back({1'b0, 16'h1234, 16'hABCD});
    exp_q.push_back({1'b1, 16'h1234, 16'hABCD});
    send(16'h1234, 16'hABCD, acc);
    check("acc_c_n", 64'(acc), 64'(521));
    wait_until(1600);
    send(16'h5555, 16'hAAAA, acc);
    check("acc_d_n", 64'(acc), 64'(1601));
    wait_until(1900);
    check("lrclk_right_n1900", 64'(lrclk), 64'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset2");
    exp_q.delete();

    // Restart: held pair discarded, coincident accept at a load
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b0, 16'h0F0F, 16'hF0F0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_until(7);   check("restart_fs_n7",   64'(frameStart), 64'(0));
                     check("restart_bclk_n7", 64'(bclk), 64'(1));
    wait_until(8);   check("restart_fs_n8",   64'(frameStart), 64'(1));
                     check("restart_und_n8",  64'(underrun), 64'(1));
    wait_until(519);
    smp.leftSampleIn  = 16'h0F0F;
    smp.rightSampleIn = 16'hF0F0;
    smp.sampleValid   = 1'b1;
    @(posedge clk);
    #1;
    smp.sampleValid = 1'b0;
    check("coinc_und",   64'(underrun), 64'(1));
    check("coinc_fs",    64'(frameStart), 64'(1));
    check("coinc_ready", 64'(smp.sampleReady), 64'(0));
    wait_until(1032);
    check("e_fs",    64'(frameStart), 64'(1));
    check("e_und",   64'(underrun), 64'(0));
    check("e_ready", 64'(smp.sampleReady), 64'(1));
    wait_until(1543);

    check("frames_checked", 64'(frames_done), 64'(8));
    check("exp_q_drained",  64'(exp_q.size()), 64'(0));
    rst_n = 1'b0;
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- Serialises processed stereo samples from the effects chain into a standard Philips I2S stream for the codec DAC.
- Sits directly downstream of the distortion stage and consumes its 16-bit signed left/right outputs.
- Generates BCLK, LRCLK and SDATA itself from the system clock.
- Has a one-frame holding buffer with a valid/ready handshake, so upstream effects can run at any rate up to one sample pair per frame.

Parameters:
- SAMPLE_WIDTH, 16, bits per channel sample (two's complement).
- SLOT_WIDTH, 32, BCLK periods per channel slot; must be >= SAMPLE_WIDTH+1.
- BCLK_DIV, 4, system clocks per BCLK half-period; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- leftSampleIn  in  SAMPLE_WIDTH  signed left sample from the effects chain.
- rightSampleIn  in  SAMPLE_WIDTH  signed right sample from the effects chain.
- sampleValid  in  1  left/right pair is valid this cycle.
- sampleReady  out  1  holding register can accept a pair.
- bclk  out  1  I2S bit clock.
- lrclk  out  1  I2S word select: 0 = left, 1 = right.
- sdata  out  1  I2S serial data, MSB first.
- frameStart  out  1  one-clk pulse when a new frame is loaded.
- underrun  out  1  one-clk pulse when a frame load finds the holding register empty.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n); the polarity and synchronicity are fixed.
- Reset values:
  - bclk=0, lrclk=0, sdata=0, sampleReady=1, frameStart=0, underrun=0.
  - divCnt=0, bitCnt=2*SLOT_WIDTH-1.
  - holding register empty; active frame register = 0/0.
- Divider:
  - divCnt counts 0..BCLK_DIV-1 and wraps.
  - On the cycle divCnt==BCLK_DIV-1, bclk toggles.
  - A toggle from 1 to 0 is a "fall event"; all serial outputs update only on fall events.
- Bit counter:
  - On each fall event, bitCnt increments modulo 2*SLOT_WIDTH.
  - lrclk = (new bitCnt >= SLOT_WIDTH), registered.
  - k = new bitCnt mod SLOT_WIDTH.
- Data (one-BCLK I2S delay):
  - For k in 1..SAMPLE_WIDTH, sdata = active[channel][SAMPLE_WIDTH-k]. Channel is left while lrclk=0, right while lrclk=1.
  - Otherwise sdata = 0 (k=0 and padding bits).
  - Receiver samples sdata on bclk rising edges.
- Frame load: on the fall event where bitCnt wraps to 0:
  - If the holding register is full: active <= holding, holding empty, frameStart pulses.
  - If empty: active keeps its previous pair (repeat last frame), frameStart and underrun both pulse.
- Handshake:
  - sampleReady = holding register empty.
  - Accept on sampleValid && sampleReady: capture both channels, holding becomes full, sampleReady deasserts next cycle.
  - sampleValid while not ready is ignored; the data is not captured and the source must hold it.
  - Accept in the same cycle as a frame load with holding empty: the load counts as an underrun, and the new pair is captured into holding for the next frame.
- Arithmetic: no scaling or saturation; samples pass bit-exact. SAMPLE_WIDTH bits are MSB-justified in the slot.
- Timing with defaults (N = clk rising edges after rst_n deasserts):
  - bclk rises at N=4; first fall event at N=8 (frame load, lrclk=0).
  - Left MSB at N=16, left LSB at N=136.
  - lrclk=1 at N=264; right MSB at N=272.
  - Frame period = 512 clk.
- Reset mid-operation: all state returns to reset values immediately; any partly shifted frame and any held sample are discarded.

Decomposition:
- Shared package audio_pkg:
  - typedef sample_t (signed SAMPLE_WIDTH); typedef stereo_t {sample_t left, right}.
  - Constants DEFAULT_SLOT_WIDTH=32 and DEFAULT_BCLK_DIV=4.
- One natural sub-module: i2s_clock_gen (divider plus bit counter). It outputs bclk, lrclk, fallEvent, slotBit and frameWrap. The top level holds the holding/active registers and the data mux.

Test Plan:
- Reset release, no input -> bclk period 8 clk; lrclk low for 256 clk then high for 256; sdata stays 0; underrun pulses at N=8 and every 512 clk after.
- Write left=16'h8001, right=16'h7FFE before N=8 -> frameStart at N=8, no underrun. Left slot bits k=1..16 read 1000_0000_0000_0001, right slot 0111_1111_1111_1110, all other bits 0.
- Write pair A, then assert sampleValid with pair B during frame A -> B accepted immediately, sampleReady=0. A third pair C is held off until the frame 1 load, then accepted (sampleReady back to 1 one cycle after the load). Frames stream A, B, C.
- No write for frame 2 after pair 16'h1234/16'hABCD -> underrun pulse; frame 2 repeats 1234/ABCD.
- Accept coincident with the frame-load cycle while holding empty -> underrun at that load; the new pair appears in the following frame.
- rst_n low mid right slot, then released -> outputs return to reset values at once; the stream restarts with the first fall event 8 clk after release and no held data.
